matrix_kbd_scan: RTL
====================

MATRIX_KBD_SCAN -- requirements
Module: matrix_kbd_scan

Interface
REQ-001 SHALL have parameter ROWS, default 4: number of driven row lines (>=2).
REQ-002 SHALL have parameter COLS, default 4: number of sensed column lines (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 1000: clock cycles per row dwell (>=2).
REQ-004 SHALL have parameter DEBOUNCE, default 3: consecutive differing samples required to change a key state (>=1).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: event queue entries (power of 2, >=2).
REQ-006 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-008 SHALL have port column_i  input  COLS  column sense, 1 = key closed on the driven row.
REQ-009 SHALL have port row_o  output  ROWS  one-hot active-high row drive.
REQ-010 SHALL have port keys_o  output  ROWS*COLS  debounced key state, bit index row*COLS+col.
REQ-011 SHALL have port evt_valid_o  output  1  event available at queue head.
REQ-012 SHALL have port evt_ready_i  input  1  consumer accepts head event.
REQ-013 SHALL have port evt_code_o  output  $clog2(ROWS*COLS)  key index row*COLS+col of head event.
REQ-014 SHALL have port evt_press_o  output  1  1 = press, 0 = release.
REQ-015 SHALL have port overflow_o  output  1  sticky flag, event dropped on full queue.
REQ-016 SHALL have port clr_ovf_i  input  1  synchronous clear of overflow_o.

Function
REQ-017 SHALL run the FSM DWELL -> SAMPLE -> EMIT -> DWELL, advancing the row on leaving EMIT, ROWS-1 wrapping to 0.
REQ-018 SHALL hold row_o one-hot on the current row throughout DWELL, SAMPLE and EMIT of that row.
REQ-019 SHALL stay in DWELL exactly SCAN_DIV cycles, latch column_i in the single SAMPLE cycle, and spend exactly COLS cycles in EMIT (row period SCAN_DIV+1+COLS).
REQ-020 SHALL in EMIT cycle c process key (row,c): sample equal to keys_o bit -> per-key counter cleared; differing -> counter incremented; on reaching DEBOUNCE the keys_o bit toggles, the counter clears and an event is pushed.
REQ-021 SHALL generate at most one event per cycle, so simultaneous changes across columns queue in column order.
REQ-022 SHALL present the queue head as evt_valid_o = not empty; evt_code_o/evt_press_o stable while evt_valid_o=1 and evt_ready_i=0.
REQ-023 SHALL pop on evt_valid_o & evt_ready_i; the next entry appears the following cycle.
REQ-024 SHALL accept a push when not full, or when full with a pop in the same cycle.
REQ-025 SHALL on push to a full queue without pop drop the event, set overflow_o, and still update keys_o.
REQ-026 SHALL give set priority over clr_ovf_i when both occur in the same cycle.
REQ-027 SHALL pop from an empty queue as a no-op; FIFO pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 SHALL on rst_ni=0 immediately force: row_o=one-hot row 0, FSM=DWELL, dwell count 0, keys_o=0, all debounce counters 0, queue empty, evt_valid_o=0, evt_code_o=0, evt_press_o=0, overflow_o=0.
REQ-029 SHALL discard queued events and partial debounce progress on reset mid-operation; scanning restarts from row 0 on the first edge after release.

Configuration
REQ-030 SHALL with macro MATRIX_KBD_SCAN_RELEASE_EN defined queue both press (evt_press_o=1) and release (evt_press_o=0) events.
REQ-031 SHALL without MATRIX_KBD_SCAN_RELEASE_EN queue press events only, evt_press_o constant 1; releases still update keys_o.

Verification (ROWS=4, COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4; row period 13, frame 52 cycles)
REQ-032 SHALL cover reset: after rst_ni low -> row_o=4'b0001, keys_o=0, evt_valid_o=0, overflow_o=0; after release row_o=4'b0010 at cycle 13.
REQ-033 SHALL cover press: model key(1,1) (column_i[1]=row_o[1]) held from cycle 0, evt_ready_i=1 -> keys_o[5]=1 and one event code 5, press=1, during frame 3.
REQ-034 SHALL cover bounce: key(1,1) closed for 2 frames then opened -> keys_o stays 0, no event.
REQ-035 SHALL cover release: press key 5, then open it 3 frames -> with macro event code 5 press=0; without macro no event, keys_o[5]=0.
REQ-036 SHALL cover overflow: evt_ready_i=0, keys 0,1,2,3,4 closed -> 4 events queued (codes 0,1,2,3), overflow_o=1, keys_o[4:0]=5'b11111; clr_ovf_i pulse -> overflow_o=0.
REQ-037 SHALL cover mid-operation reset: with 2 events queued, rst_ni low mid-EMIT -> evt_valid_o=0 and keys_o=0 before the next clock edge.

Source files
------------

// File: rtl/matrix_kbd_scan.sv
// Matrix keyboard scanner: one-hot row drive, per-key debounce and a small event queue.
// Define MATRIX_KBD_SCAN_RELEASE_EN to queue release events as well as presses.
module matrix_kbd_scan #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [COLS-1:0]              column_i,
  output logic [ROWS-1:0]              row_o,
  output logic [ROWS*COLS-1:0]         keys_o,
  output logic                         evt_valid_o,
  input  logic                         evt_ready_i,
  output logic [$clog2(ROWS*COLS)-1:0] evt_code_o,
  output logic                         evt_press_o,
  output logic                         overflow_o,
  input  logic                         clr_ovf_i
);

  localparam int KEYS   = ROWS * COLS;
  localparam int CODE_W = $clog2(KEYS);
  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DB_W   = $clog2(DEBOUNCE + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  generate
    if (ROWS < 2) begin : g_bad_rows
      $error("matrix_kbd_scan: ROWS must be >= 2");
    end
    if (COLS < 2) begin : g_bad_cols
      $error("matrix_kbd_scan: COLS must be >= 2");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
      $error("matrix_kbd_scan: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE < 1) begin : g_bad_db
      $error("matrix_kbd_scan: DEBOUNCE must be >= 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("matrix_kbd_scan: FIFO_DEPTH must be a power of 2, >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {DWELL, SAMPLE, EMIT} state_t;

  state_t            state;
  state_t            state_next;
  logic [DIV_W-1:0]  dwell_cnt;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [COLS-1:0]   sample;
  logic              dwell_done;
  logic              emit_last;
  logic              emit_active;

  assign dwell_done = (dwell_cnt == DIV_W'(SCAN_DIV - 1));
  assign emit_last  = (col == COL_W'(COLS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= DWELL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      DWELL:   if (dwell_done) state_next = SAMPLE;
      SAMPLE:  state_next = EMIT;
      EMIT:    if (emit_last) state_next = DWELL;
      default: state_next = DWELL;
    endcase
  end

  always_comb begin
    row_o       = '0;
    row_o[row]  = 1'b1;
    emit_active = (state == EMIT);
  end

  // Row advances only when the last column of the current row has been processed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dwell_cnt <= '0;
      row       <= '0;
      col       <= '0;
      sample    <= '0;
    end else begin
      case (state)
        DWELL: begin
          dwell_cnt <= dwell_done ? '0 : dwell_cnt + 1'b1;
        end
        SAMPLE: begin
          sample <= column_i;
          col    <= '0;
        end
        EMIT: begin
          if (emit_last) begin
            col <= '0;
            row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic [CODE_W-1:0] key_idx;
  logic [DB_W-1:0]   db_cnt [KEYS];
  logic [KEYS-1:0]   keys;
  logic [DB_W-1:0]   cur_cnt;
  logic              cur_bit;
  logic              cur_key;
  logic              differ;
  logic              toggle;
  logic              push;

  always_comb begin
    key_idx = CODE_W'(row) * CODE_W'(COLS) + CODE_W'(col);
    cur_bit = sample[col];
    cur_key = keys[key_idx];
    cur_cnt = db_cnt[key_idx];
    differ  = (cur_bit != cur_key);
    toggle  = emit_active && differ && (cur_cnt == DB_W'(DEBOUNCE - 1));
`ifdef MATRIX_KBD_SCAN_RELEASE_EN
    push    = toggle;
`else
    push    = toggle && cur_bit;
`endif
  end

  // One key per EMIT cycle, so at most one event can be generated per clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      keys <= '0;
      for (int k = 0; k < KEYS; k++) begin
        db_cnt[k] <= '0;
      end
    end else if (emit_active) begin
      if (!differ || toggle) begin
        db_cnt[key_idx] <= '0;
      end else begin
        db_cnt[key_idx] <= cur_cnt + 1'b1;
      end
      if (toggle) begin
        keys[key_idx] <= cur_bit;
      end
    end
  end

  assign keys_o = keys;

  logic [CODE_W-1:0] code_mem [FIFO_DEPTH];
`ifdef MATRIX_KBD_SCAN_RELEASE_EN
  logic              press_mem [FIFO_DEPTH];
`endif
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              ovf;

  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
             (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    pop    = !empty && evt_ready_i;
    accept = push && (!full || pop);
    drop   = push && full && !pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: the head outputs are masked whenever the queue is empty.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      code_mem[wr_ptr[PTR_W-1:0]]  <= key_idx;
`ifdef MATRIX_KBD_SCAN_RELEASE_EN
      press_mem[wr_ptr[PTR_W-1:0]] <= cur_bit;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf_i) begin
      ovf <= 1'b0;
    end
  end

  assign overflow_o  = ovf;
  assign evt_valid_o = !empty;
  assign evt_code_o  = empty ? '0 : code_mem[rd_ptr[PTR_W-1:0]];
`ifdef MATRIX_KBD_SCAN_RELEASE_EN
  assign evt_press_o = !empty && press_mem[rd_ptr[PTR_W-1:0]];
`else
  assign evt_press_o = 1'b1;
`endif

endmodule
